// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store subsystem.
// - RISC-V funct3 size codes for loads and stores
// - Init/idle FSM state encoding
// - Byte-enable generation for stores
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } dmem_state_e;

    // Byte lanes touched by a store of size f3 at (already aligned) offset off.
    // Illegal sizes enable nothing.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port block RAM, DEPTH x 32, four byte-write lanes, synchronous
// read-first output. Written in the plain form that block-RAM inference
// tools recognise.
// Ports:
//   clk       - clock
//   en_i      - port enable (read and/or write this cycle)
//   we_i      - per-byte write enables
//   addr_i    - word index
//   wdata_i   - write data
//   rdata_o   - read data, valid the cycle after an enabled access
module dmem_bram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ls.sv
// Data-memory subsystem: byte/half/word loads and stores with sign/zero
// extension, byte write enables, one-cycle registered read with a valid
// pulse, and hardware zero-fill of the RAM after every reset.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being silently aligned.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   req_valid / req_ready   - request handshake; accepted when both are 1.
//                             req_ready is 0 while the RAM is being zeroed.
//   mem_read, mem_write     - access kind (write wins if both set)
//   funct3                  - RISC-V size code
//   addr_i, wdata_m_i       - byte address, right-aligned store data
//   rdata_m_o, rvalid_o     - load result and its one-cycle valid pulse
//   err_o                   - access-fault pulse, in the response cycle
//   dbg_state_o             - current FSM state
module data_mem_ls
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_m_i,
    output logic [DATA_W-1:0] rdata_m_o,
    output logic              rvalid_o,
    output logic              err_o,
    output dmem_state_e       dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             accept, is_store, is_load, f3_legal, misalign, fault;
    logic [1:0]       off;
    logic [IDX_W-1:0] word_idx;

    logic             ram_en;
    logic [3:0]       ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_wdata, ram_rdata;

    logic             rvalid_q, err_q, ld_zero_q;
    logic [2:0]       ld_f3_q;
    logic [1:0]       ld_off_q;
    logic [31:0]      hold_q, ext;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    // Upper address bits beyond DEPTH wrap and are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^addr_i;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign req_ready   = (state_q == S_IDLE);
    assign dbg_state_o = state_q;

    // ---------------- request decode ----------------
    assign accept   = req_valid & req_ready;
    assign is_store = accept & mem_write;
    assign is_load  = accept & mem_read & ~mem_write;
    assign word_idx = addr_i[IDX_W+1:2];

    always_comb begin
        if (mem_write) f3_legal = funct3 inside {F3_B, F3_H, F3_W};
        else           f3_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((funct3 == F3_H || funct3 == F3_HU) && addr_i[0]) ||
                      ((funct3 == F3_W) && (addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = (is_store | is_load) & (~f3_legal | misalign);

    // Low address bits used for lane selection, forced to natural alignment.
    always_comb begin
        off = addr_i[1:0];
        case (funct3)
            F3_H, F3_HU: off = {addr_i[1], 1'b0};
            F3_W:        off = 2'b00;
            default: ;
        endcase
    end

    // ---------------- RAM port ----------------
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = word_idx;
        ram_wdata = wdata_m_i;
        if (state_q == S_INIT) begin
            ram_en    = 1'b1;
            ram_we    = 4'b1111;
            ram_addr  = cnt_q;
            ram_wdata = '0;
        end else if (accept) begin
            ram_en = 1'b1;
            if (is_store && !fault) ram_we = byte_en(funct3, off);
            case (funct3)
                F3_B:    ram_wdata = {4{wdata_m_i[7:0]}};
                F3_H:    ram_wdata = {2{wdata_m_i[15:0]}};
                default: ram_wdata = wdata_m_i;
            endcase
        end
    end

    dmem_bram #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_bram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            ld_zero_q <= 1'b0;
            ld_f3_q   <= F3_W;
            ld_off_q  <= 2'b00;
            hold_q    <= '0;
        end else begin
            rvalid_q  <= is_load;
            err_q     <= fault;
            ld_zero_q <= fault;
            if (is_load) begin
                ld_f3_q  <= funct3;
                ld_off_q <= off;
            end
            if (rvalid_q) hold_q <= rdata_m_o;
        end
    end

    // Extension works straight off the RAM output so data lands in the same
    // cycle as rvalid; hold_q keeps the last result visible between loads.
    always_comb begin
        lane_b = ram_rdata[8*ld_off_q +: 8];
        lane_h = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (ld_f3_q)
            F3_B:    ext = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ext = {24'h0, lane_b};
            F3_H:    ext = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ext = {16'h0, lane_h};
            default: ext = ram_rdata;
        endcase
        if (ld_zero_q) ext = '0;
    end

    assign rdata_m_o = rvalid_q ? ext : hold_q;
    assign rvalid_o  = rvalid_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_data_mem_ls.sv
// Bench for data_mem_ls (DEPTH=16): directed load/store vectors, expected
// responses queued at issue time and checked by an independent monitor.
module tb_data_mem_ls;
    import dmem_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16;
    localparam int W      = 34;   // {rvalid, err, data}

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [2:0]        funct3 = 3'b000;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              err;
    dmem_state_e       dbg_state;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_miss = 0;
    int pulse_cnt = 0;

    data_mem_ls #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr_i      (addr),
        .wdata_m_i   (wdata),
        .rdata_m_o   (rdata),
        .rvalid_o    (rvalid),
        .err_o       (err),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every DUT response pops one expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && (rvalid || err)) begin
            if (rvalid) pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {rvalid, err, rdata}, '0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {rvalid, err, (rvalid ? rdata : 32'h0)}, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        op(1'b1, 1'b0, f3, a, 32'h0);
        exp_q.push_back({1'b1, 1'b0, d});
    endtask

    task automatic ld_err(input logic [2:0] f3, input logic [ADDR_W-1:0] a);
        op(1'b1, 1'b0, f3, a, 32'h0);
        exp_q.push_back({1'b1, 1'b1, 32'h0});
    endtask

    task automatic st(input logic [2:0] f3, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        op(1'b0, 1'b1, f3, a, wd);
    endtask

    task automatic st_err(input logic [2:0] f3, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        op(1'b0, 1'b1, f3, a, wd);
        exp_q.push_back({1'b0, 1'b1, 32'h0});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Release reset on a negedge with a load request held high; the request
    // must be ignored, and req_ready must stay low for exactly DEPTH cycles.
    task automatic release_and_init(input string nm);
        int n;
        req_valid = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        funct3    = F3_W;
        addr      = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk({nm, "_state_init"}, W'(dbg_state), W'(S_INIT));
        n = 0;
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        mem_read  = 1'b0;
        chk({nm, "_init_cycles"}, W'(n), W'(DEPTH));
        chk({nm, "_state_idle"}, W'(dbg_state), W'(S_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rvalid, err, rdata}, '0);
        chk("reset_ready", W'(req_ready), '0);

        release_and_init("init1");

        // Whole RAM reads back zero after init.
        for (int i = 0; i < DEPTH; i++) ld(F3_W, ADDR_W'(i * 4), 32'h0);

        // Word store, then all sub-word load flavours.
        st(F3_W, 14'h8, 32'hDEADBEEF);
        ld(F3_B,  14'h8, 32'hFFFFFFEF);
        ld(F3_BU, 14'hB, 32'h000000DE);
        ld(F3_H,  14'hA, 32'hFFFFDEAD);
        ld(F3_HU, 14'h8, 32'h0000BEEF);

        // Byte store; rdata must hold the previous result while rvalid is low.
        st(F3_B, 14'h9, 32'h0000005A);
        @(posedge clk);
        #1 chk("hold_rdata", {rvalid, err, rdata}, {1'b0, 1'b0, 32'h0000BEEF});
        ld(F3_W, 14'h8, 32'hDEAD5AEF);
        ld(F3_B, 14'h9, 32'h0000005A);
        st(F3_H, 14'hA, 32'hFFFF1234);
        ld(F3_W, 14'h8, 32'h12345AEF);

        // Store followed immediately by a load of the same word.
        st(F3_W, 14'h4, 32'hCAFEF00D);
        ld(F3_W, 14'h4, 32'hCAFEF00D);

        // Four back-to-back loads give four rvalid pulses.
        idle(1);
        base = pulse_cnt;
        ld(F3_W,  14'h4, 32'hCAFEF00D);
        ld(F3_HU, 14'h6, 32'h0000CAFE);
        ld(F3_B,  14'h4, 32'h0000000D);
        ld(F3_W,  14'h48, 32'h12345AEF);   // wraps onto word 2
        idle(2);
        chk("b2b_pulses", W'(pulse_cnt - base), W'(4));

        // Read+write together acts as a store only.
        op(1'b1, 1'b1, F3_W, 14'hC, 32'h00000055);
        ld(F3_W, 14'hC, 32'h00000055);

        // Illegal sizes.
        st(F3_W, 14'h0, 32'h11223344);
        st_err(3'b011, 14'h0, 32'hFFFFFFFF);
        st_err(F3_BU, 14'h0, 32'hFFFFFFFF);
        ld(F3_W, 14'h0, 32'h11223344);
        ld_err(3'b111, 14'h0);
        ld_err(3'b110, 14'h4);

        // Misaligned half/word accesses.
`ifdef DMEM_MISALIGN_TRAP_EN
        ld_err(F3_W, 14'h2);
        ld_err(F3_H, 14'h3);
        st_err(F3_W, 14'h1, 32'hFFFFFFFF);
        ld(F3_W, 14'h0, 32'h11223344);
`else
        ld(F3_W,  14'h2, 32'h11223344);
        ld(F3_H,  14'h3, 32'h00001122);
        ld(F3_HU, 14'h1, 32'h00003344);
        st(F3_W,  14'h1, 32'hA5A5A5A5);
        ld(F3_W,  14'h0, 32'hA5A5A5A5);
`endif
        idle(3);

        // Reset in the middle of a load burst.
        ld(F3_W, 14'h8, 32'h12345AEF);
        ld(F3_W, 14'h8, 32'h12345AEF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_outputs", {rvalid, err, rdata}, '0);
        chk("midrst_ready", W'(req_ready), '0);
        repeat (2) @(negedge clk);
        release_and_init("init2");
        ld(F3_W, 14'h8, 32'h0);
        ld(F3_W, 14'h4, 32'h0);
        idle(2);

        // Drain: every expected response must have appeared.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_mem_ls.md
Name: data_mem_ls

Overview:
- Parametrised data-memory subsystem for the single-cycle/pipelined CPU; successor to the plain word-wide data RAM.
- Adds byte/half/word load-store with sign/zero extension, byte-write enables, a registered read pipeline with valid flag, and hardware zero-initialisation after reset.
- Sits between the execute/mem stage and the on-chip block RAM, which is inferred inside this block.

Parameters:
- ADDR_W, 14, byte-address width seen by the CPU.
- DEPTH, 4096, number of 32-bit words; must be ≤ 2^(ADDR_W-2) and a power of two.
- DATA_W, 32, data width; fixed at 32, present for package consistency only.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  access request this cycle.
- req_ready  out  1  block accepts requests; 0 during zero-init.
- mem_read  in  1  load request (qualified by req_valid).
- mem_write  in  1  store request (qualified by req_valid).
- funct3  in  3  RISC-V size code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
- addr_i  in  ADDR_W  byte address.
- wdata_m_i  in  32  store data, right-aligned.
- rdata_m_o  out  32  load result, extended per funct3.
- rvalid_o  out  1  rdata_m_o valid (one-cycle pulse per load).
- err_o  out  1  access-fault pulse, aligned with the response cycle.

Behaviour:
- Reset (async, rst_n=0): rdata_m_o=0, rvalid_o=0, err_o=0, req_ready=0, FSM→INIT, init counter=0. RAM contents are not reset asynchronously.
- FSM states:
  - INIT: each cycle, write zero to word[cnt] and increment cnt; after word DEPTH-1 → IDLE. Takes exactly DEPTH cycles after reset release; req_ready=0 throughout, and requests are ignored.
  - IDLE: req_ready=1.
- Accept condition: req_valid & req_ready. mem_read & mem_write both set → treated as store only; the load is dropped and no rvalid is issued.
- Word index = addr_i[ADDR_W-1:2] modulo DEPTH; upper bits are ignored (wrap).
- Stores, same-cycle RAM write:
  - sb: byte lane addr[1:0], data = wdata[7:0] replicated.
  - sh: lane pair addr[1]; data = wdata[15:0] replicated.
  - sw: all lanes.
- Loads, latency 1: RAM read at cycle N; registered funct3 and addr[1:0] select/extend at N+1. rdata_m_o and rvalid_o update at N+1.
  - lb/lbu: byte lane, sign- or zero-extended to 32.
  - lh/lhu: halfword lane, sign- or zero-extended to 32.
  - lw: full word.
  - rdata_m_o holds its last value when rvalid_o=0.
- Back-to-back loads: one accepted per cycle; full throughput.
- Read-during-write, same word, same cycle: cannot occur (single port, store wins). A load in cycle N+1 after a store to the same word in cycle N returns the new data.
- Illegal funct3 (011, 110, 111, or 100/101 on a store): no RAM write; err_o pulses at N+1; for a load, rvalid_o=1 with rdata_m_o=0.
- rst_n asserted mid-operation: pending rvalid/err are cleared immediately; an in-flight write is not guaranteed; re-initialisation runs on release.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0, suppress the write and pulse err_o at N+1; a faulting load gives rvalid_o=1 with rdata_m_o=0.
- Undefined: misaligned low address bits are forced to alignment (addr[0] cleared for halfwords, addr[1:0] cleared for words); err_o is driven only by illegal funct3.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum S_INIT, S_IDLE.
  - Function for byte-enable generation.
- Sub-module dmem_bram: single-port, 4 byte-enable lanes, synchronous read, DEPTH×32. Keeps inference portable across Vivado/simulators.
- Lane steering and extension stay in the top level.

Test Plan:
- Reset release, DEPTH=16 → req_ready=0 for 16 cycles then 1; lw from 0x0..0x3C all return 0x00000000.
- sw 0xDEADBEEF @0x8; lb 0x8→0xFFFFFFEF, lbu 0xB→0x000000DE, lh 0xA→0xFFFFDEAD, lhu 0x8→0x0000BEEF, each rvalid one cycle later.
- sb 0x5A @0x9 over 0xDEADBEEF → lw 0x8 = 0xDEAD5AEF; sh 0x1234 @0xA → 0x12345AEF.
- Store @0x4 then load @0x4 on the very next cycle → new data; 4 back-to-back loads → 4 consecutive rvalid pulses.
- funct3=011 store @0x0 → err_o pulse, memory unchanged; with DMEM_MISALIGN_TRAP_EN, lw @0x2 → err_o=1, rdata=0; without it → returns word @0x0.
- rst_n low during a load burst → rvalid_o/err_o drop to 0 immediately; INIT reruns on release.
